// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I-wide constants, types and helpers shared by the core blocks.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int CNT_W      = 16;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      return value;
    end
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input arbiter, round-robin or A-priority, grants combinational from requests.
module rr_arbiter2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);
  import rv32i_pkg::*;

  grant_e last_grant_q;
  grant_e last_grant_d;
  logic   gnt_a;
  logic   gnt_b;

  // Grants are gated by reset so nothing is accepted while the block is held in reset.
  always_comb begin
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    last_grant_d = last_grant_q;
    if (reset_i) begin
      if (req_a_i && (!req_b_i || (FIXED_PRIO != 0) || (last_grant_q == GRANT_B))) begin
        gnt_a = 1'b1;
      end else if (req_b_i) begin
        gnt_b = 1'b1;
      end
    end
    if (gnt_a) begin
      last_grant_d = GRANT_A;
    end else if (gnt_b) begin
      last_grant_d = GRANT_B;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      last_grant_q <= GRANT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign gnt_a_o = gnt_a;
  assign gnt_b_o = gnt_b;

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - merges ALU and load-unit writebacks onto one register file write port.
module regfile_write_arbiter #(
  parameter int XLEN       = rv32i_pkg::XLEN,
  parameter int FIXED_PRIO = 0
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             a_valid_i,
  input  logic [rv32i_pkg::REG_ADDR_W-1:0] a_addr_i,
  input  logic [XLEN-1:0]                  a_data_i,
  output logic                             a_ready_o,
  input  logic                             b_valid_i,
  input  logic [rv32i_pkg::REG_ADDR_W-1:0] b_addr_i,
  input  logic [XLEN-1:0]                  b_data_i,
  output logic                             b_ready_o,
  output logic                             we3_o,
  output logic [rv32i_pkg::REG_ADDR_W-1:0] a3_o,
  output logic [XLEN-1:0]                  wd3_o,
  output logic [rv32i_pkg::CNT_W-1:0]      conflict_cnt_o
);
  import rv32i_pkg::*;

  logic                  gnt_a;
  logic                  gnt_b;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;

  logic                  we3_q,  we3_d;
  logic [REG_ADDR_W-1:0] a3_q,   a3_d;
  logic [XLEN-1:0]       wd3_q,  wd3_d;
  logic [CNT_W-1:0]      cnt_q,  cnt_d;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_a_i (a_valid_i),
    .req_b_i (b_valid_i),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  always_comb begin
    sel_addr = gnt_b ? b_addr_i : a_addr_i;
    sel_data = gnt_b ? b_data_i : a_data_i;
    we3_d    = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    cnt_d    = cnt_q;
    // x0 writes are handshaken normally but never reach the register file.
    if ((gnt_a || gnt_b) && (sel_addr != REG_ZERO)) begin
      we3_d = 1'b1;
      a3_d  = sel_addr;
      wd3_d = sel_data;
    end
    if (a_valid_i && b_valid_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
      cnt_q <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      cnt_q <= cnt_d;
    end
  end

  assign a_ready_o      = gnt_a;
  assign b_ready_o      = gnt_b;
  assign we3_o          = we3_q;
  assign a3_o           = a3_q;
  assign wd3_o          = wd3_q;
  assign conflict_cnt_o = cnt_q;

endmodule
